// File: rtl/sc_sync_controller.sv
// Run-time sequencer for the Schmidl-Cox trigger path: gates detector triggers
// into the framer, times out stuck frames, enforces holdoff and keeps status counters.
module sc_sync_controller #(
  parameter logic [7:0] SR_CTRL    = 8'd6,
  parameter logic [7:0] SR_TIMEOUT = 8'd7,
  parameter logic [7:0] SR_HOLDOFF = 8'd8,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  input  logic [39:0]          trig_i_tdata,
  input  logic                 trig_i_tlast,
  input  logic                 trig_i_tvalid,
  output logic                 trig_i_tready,
  output logic [39:0]          trig_o_tdata,
  output logic                 trig_o_tlast,
  output logic                 trig_o_tvalid,
  input  logic                 trig_o_tready,
  input  logic                 smp_tvalid,
  input  logic                 smp_tready,
  input  logic                 sof,
  input  logic                 eof,
  output logic                 dp_clear,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] timeout_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEARCH  = 2'd1;
  localparam logic [1:0] S_FRAME   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  logic        enable;
  logic        one_shot;
  logic [23:0] timeout_r;
  logic [15:0] holdoff_r;
  logic [23:0] beat_cnt;
  logic        sof_seen;

  logic        wr_ctrl;
  logic        en_now;
  logic        os_now;
  logic        soft_clr;
  logic        beat;
  logic [24:0] beat_inc;
  logic        to_hit;
  logic        ho_hit;
  logic        in_search;
  logic [1:0]  exit_state;
  logic [1:0]  nxt;
  logic        clr;
  logic        frame_inc;
  logic        to_inc;
  logic        drop_inc;
  logic        en_clear;
  logic        unused_set_hi;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  assign unused_set_hi = ^set_data[31:24];

  // Control writes are honoured in the cycle they arrive so disable/soft_clear act next cycle
  assign wr_ctrl    = set_stb && (set_addr == SR_CTRL);
  assign en_now     = wr_ctrl ? set_data[0] : enable;
  assign os_now     = wr_ctrl ? set_data[1] : one_shot;
  assign soft_clr   = wr_ctrl && set_data[2];

  assign beat       = smp_tvalid & smp_tready;
  assign beat_inc   = {1'b0, beat_cnt} + 25'd1;
  assign to_hit     = beat && (timeout_r != 24'd0) && (beat_inc >= {1'b0, timeout_r});
  assign ho_hit     = beat && (beat_inc >= {9'd0, holdoff_r});
  assign exit_state = (en_now && !os_now) ? S_SEARCH : S_IDLE;

  assign in_search     = (state == S_SEARCH);
  assign trig_o_tdata  = trig_i_tdata;
  assign trig_o_tlast  = trig_i_tlast;
  assign trig_o_tvalid = in_search & trig_i_tvalid;
  assign trig_i_tready = in_search ? trig_o_tready : 1'b1;
  assign drop_inc      = trig_i_tvalid && !in_search;

  always_comb begin
    nxt       = state;
    clr       = 1'b0;
    frame_inc = 1'b0;
    to_inc    = 1'b0;
    en_clear  = 1'b0;
    case (state)
      S_IDLE: if (en_now) nxt = S_SEARCH;
      S_SEARCH: begin
        if (!en_now)                            nxt = S_IDLE;
        else if (trig_o_tvalid && trig_o_tready) nxt = S_FRAME;
      end
      S_FRAME: begin
        if (eof) begin
          frame_inc = 1'b1;
          if (!en_now)                nxt = S_IDLE;
          else if (holdoff_r != 16'd0) nxt = S_HOLDOFF;
          else begin
            nxt      = exit_state;
            en_clear = os_now;
          end
        end else if (!en_now) begin
          nxt = S_IDLE;
          clr = 1'b1;
        end else if (to_hit) begin
          to_inc = 1'b1;
          clr    = 1'b1;
          if (holdoff_r != 16'd0) nxt = S_HOLDOFF;
          else begin
            nxt      = exit_state;
            en_clear = os_now;
          end
        end
      end
      S_HOLDOFF: begin
        if (!en_now) nxt = S_IDLE;
        else if (ho_hit) begin
          nxt      = exit_state;
          en_clear = os_now;
        end
      end
      default: nxt = S_IDLE;
    endcase
    // soft_clear wins over whatever else happened this cycle
    if (soft_clr) begin
      nxt      = en_now ? S_SEARCH : S_IDLE;
      clr      = 1'b1;
      en_clear = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      enable        <= 1'b0;
      one_shot      <= 1'b0;
      timeout_r     <= 24'd0;
      holdoff_r     <= 16'd0;
      beat_cnt      <= 24'd0;
      sof_seen      <= 1'b0;
      dp_clear      <= 1'b0;
      frame_count   <= '0;
      timeout_count <= '0;
      drop_count    <= '0;
    end else begin
      state    <= nxt;
      dp_clear <= clr;

      if (wr_ctrl) begin
        enable   <= set_data[0];
        one_shot <= set_data[1];
      end
      if (en_clear) enable <= 1'b0;
      if (set_stb && (set_addr == SR_TIMEOUT)) timeout_r <= set_data[23:0];
      if (set_stb && (set_addr == SR_HOLDOFF)) holdoff_r <= set_data[15:0];

      if ((nxt != state) || soft_clr)        beat_cnt <= 24'd0;
      else if (beat && (beat_cnt != '1))     beat_cnt <= beat_cnt + 24'd1;

      if ((nxt != state) || soft_clr)        sof_seen <= 1'b0;
      else if ((state == S_FRAME) && sof)    sof_seen <= 1'b1;

      if (soft_clr) begin
        frame_count   <= '0;
        timeout_count <= '0;
        drop_count    <= '0;
      end else begin
        frame_count   <= sat_inc(frame_count, frame_inc);
        timeout_count <= sat_inc(timeout_count, to_inc);
        drop_count    <= sat_inc(drop_count, drop_inc);
      end
    end
  end

endmodule

// File: doc/sc_sync_controller.md
Name: sc_sync_controller

Overview:
- Run-time sequencer for the Schmidl-Cox receive chain.
- Sits in the trigger path between the plateau detector and the periodic framer.
- Arms and disarms detection, passes one trigger per frame, and drops triggers while a frame is in progress or during a programmable holdoff.
- Enforces a frame timeout, pulses a datapath clear on abort, and keeps saturating status counters readable by software.

Parameters:
SR_CTRL, 6, settings address of control reg: bit0 enable, bit1 one_shot, bit2 soft_clear (write-1 pulse, not stored)
SR_TIMEOUT, 7, settings address of frame timeout in sample beats, 24 bits; 0 = disabled
SR_HOLDOFF, 8, settings address of post-frame holdoff in sample beats, 16 bits; 0 = none
CNT_WIDTH, 16, width of each status counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
trig_i_tdata  in  40  trigger+phase word from detector
trig_i_tlast  in  1  trigger last
trig_i_tvalid  in  1  trigger valid
trig_i_tready  out  1  trigger ready
trig_o_tdata  out  40  trigger word to framer, equal to trig_i_tdata
trig_o_tlast  out  1  equal to trig_i_tlast
trig_o_tvalid  out  1  trigger valid to framer
trig_o_tready  in  1  framer ready
smp_tvalid  in  1  monitor: framer output stream valid
smp_tready  in  1  monitor: framer output stream ready
sof  in  1  framer start-of-frame pulse
eof  in  1  framer end-of-frame pulse
dp_clear  out  1  one-cycle registered clear to datapath and framer
state  out  2  0 IDLE, 1 SEARCH, 2 FRAME, 3 HOLDOFF
frame_count  out  CNT_WIDTH  frames completed
timeout_count  out  CNT_WIDTH  frames aborted by timeout
drop_count  out  CNT_WIDTH  triggers discarded

Behaviour:
- Reset: state IDLE, all counters 0, dp_clear 0, enable/one_shot 0, timeout 0, holdoff 0. Outputs are derived from IDLE, so trig_o_tvalid=0 and trig_i_tready=1.
- Beat: smp_tvalid & smp_tready. The beat counter is internal, 24 bits, zeroed on every state entry.
- Trigger path, combinational:
  - In SEARCH: trig_o_tvalid=trig_i_tvalid and trig_i_tready=trig_o_tready.
  - Otherwise: trig_o_tvalid=0 and trig_i_tready=1. Each trig_i_tvalid beat outside SEARCH increments drop_count.
- IDLE: moves to SEARCH next cycle when enable=1.
- SEARCH:
  - An accepted trigger (trig_o_tvalid & trig_o_tready) at cycle t gives state FRAME at t+1.
  - enable=0 returns to IDLE.
- FRAME:
  - sof sets internal sof_seen.
  - eof: frame_count+1, then HOLDOFF (or directly to SEARCH/IDLE if holdoff=0).
  - Timeout when timeout!=0 and the beat count reaches timeout: timeout_count+1, dp_clear=1 for one cycle, then HOLDOFF.
  - eof and timeout in the same cycle: eof wins and no clear is issued.
  - sof and eof in the same cycle: counted as a completed frame.
- HOLDOFF:
  - Exits when the beat count reaches holdoff.
  - Exit goes to SEARCH if enable & !one_shot, else IDLE.
  - In one-shot mode, enable is cleared on exit.
- Disable mid-operation (enable written 0):
  - From FRAME: go to IDLE next cycle with a dp_clear pulse.
  - From HOLDOFF or SEARCH: go to IDLE with no clear.
- soft_clear:
  - Zeros all counters and sof_seen and pulses dp_clear.
  - Next state is SEARCH if enable, else IDLE.
  - Overrides any same-cycle transition.
  - A counter increment in the same cycle is lost.
- Settings writes to timeout/holdoff take effect immediately; the comparison uses the current register value.
- Counters saturate at all-ones and do not wrap. The beat counter saturates at 2^24-1.
- dp_clear is registered and is never asserted for more than one consecutive cycle per cause.
- eof or sof outside FRAME is ignored.

Test Plan:
- Reset, enable=1, trigger presented with trig_o_tready=1 → trigger passes through in 0 cycles; state goes 1→2 the next cycle; trig_o_tdata equals the input.
- In FRAME, 3 extra triggers → drop_count=3, trig_o_tvalid stays 0; eof with holdoff=10 → frame_count=1, state 3 for exactly 10 beats (stall smp_tready 5 cycles mid-holdoff, duration extends by 5), then state 1.
- timeout=100, no eof → at beat 100: timeout_count=1, single dp_clear pulse; eof and timeout coincident at beat 100 → frame_count+1, no dp_clear.
- one_shot=1, holdoff=0 → after one eof, state 0 and enable readback 0; a further trigger is dropped.
- enable written 0 in FRAME → IDLE next cycle plus one dp_clear pulse; soft_clear after 5 frames → all counters 0.
- Preload to 0xFFFE with CNT_WIDTH=16 (drive 2 more drops) → drop_count holds 0xFFFF; synchronous reset in HOLDOFF → all reset values the following cycle.
